// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the instruction prefetch queue.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } ifq_state_t;

    localparam logic [31:0]  NOP_INSTR = 32'h0;
    localparam int unsigned  PC_STEP   = 4;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch entry storage: DEPTH-deep circular buffer with count and flush.
// Sequential state moves on the falling clock edge, matching the fetch stage.
module ifq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(negedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (rst_n && !flush && push)
            store[wr_ptr] <= wdata;
    end

    assign rdata = store[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with a small PC/instruction queue and redirect flush.
// Optional build macro IFQ_BYPASS_EN forwards an acked word straight to decode when the queue is empty.
module instr_prefetch_queue
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] startPC,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPC,
    input  logic              deqReady,
    output logic              instValid,
    output logic [DATA_W-1:0] instOut,
    output logic [ADDR_W-1:0] instPC,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } ifq_entry_t;

    ifq_state_t        state;
    ifq_state_t        state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target_pc;
    ifq_entry_t        head;
    ifq_entry_t        wr_entry;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic              enq_c;
    logic              byp_c;
    logic              push_c;
    logic              pop_c;

    // An acked word in FETCH is kept unless a redirect kills it in the same cycle.
    assign enq_c = (state == FETCH) && imemAck && !redirect;
`ifdef IFQ_BYPASS_EN
    assign byp_c = enq_c && q_empty;
`else
    assign byp_c = 1'b0;
`endif
    assign push_c   = enq_c && !(byp_c && deqReady);
    assign pop_c    = !q_empty && deqReady && !redirect;
    assign wr_entry = '{pc: fetch_pc, instr: imemData};

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (Reset_L),
        .flush (redirect),
        .push  (push_c),
        .wdata (wr_entry),
        .pop   (pop_c),
        .rdata (head),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(negedge CLK) begin
        if (!Reset_L) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (redirect)
                    state_next = imemAck ? FETCH : DRAIN;
                else if (push_c && !pop_c && (q_count == CNT_W'(DEPTH - 1)))
                    state_next = FULL;
            end
            FULL:  if (redirect || pop_c) state_next = FETCH;
            DRAIN: if (imemAck) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imemReq  = (state == FETCH) || (state == DRAIN);
        imemAddr = fetch_pc;
    end

    // fetch_pc keeps the in-flight address while a killed request drains.
    always_ff @(negedge CLK) begin
        if (!Reset_L) begin
            fetch_pc  <= startPC;
            target_pc <= startPC;
        end else begin
            if (redirect)
                target_pc <= redirectPC;
            if (state == DRAIN) begin
                if (imemAck)
                    fetch_pc <= redirect ? redirectPC : target_pc;
            end else if (redirect) begin
                if (!((state == FETCH) && !imemAck))
                    fetch_pc <= redirectPC;
            end else if ((state == FETCH) && imemAck) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_comb begin
        instValid = 1'b0;
        instOut   = DATA_W'(NOP_INSTR);
        instPC    = '0;
        if (byp_c) begin
            instValid = 1'b1;
            instOut   = imemData;
            instPC    = fetch_pc;
        end else if (!q_empty) begin
            instValid = 1'b1;
            instOut   = head.instr;
            instPC    = head.pc;
        end
    end

endmodule
